uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  CPU store strobe; byte offered this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to transmit.
REQ-007 SHALL have port wr_ready  output  1  high when FIFO not full; a write is accepted only when wr_en and wr_ready are both high.
REQ-008 SHALL have port busy  output  1  high when FIFO non-empty or a frame is in progress.
REQ-009 SHALL have port txd  output  1  serial line, registered, idle high.

Function
REQ-010 SHALL buffer accepted bytes in a FIFO of FIFO_DEPTH entries, in order, with a count of 0..FIFO_DEPTH.
REQ-011 SHALL drive wr_ready = (count != FIFO_DEPTH) combinationally from the count register.
REQ-012 SHALL ignore wr_en when wr_ready is low: no data change and no count change, even if a pop occurs in the same cycle.
REQ-013 SHALL on a simultaneous accepted push and pop leave count unchanged, with both pointers advancing and wrapping modulo FIFO_DEPTH.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, with a baud counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-015 SHALL in IDLE, if count>0 at a rising edge, pop the head byte into the shift register, set txd<=0, clear the baud counter, and enter START.
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles; the state or bit advances when the baud counter = CLKS_PER_BIT-1.
REQ-017 SHALL in START drive txd=0, then enter DATA with txd<=shift[0].
REQ-018 SHALL in DATA send bits 0..7 LSB first; after bit 7 it enters STOP with txd<=1.
REQ-019 SHALL at the end of STOP enter START directly, popping the next byte, if count>0; otherwise it enters IDLE with txd=1.
REQ-020 SHALL produce frames of exactly 10*CLKS_PER_BIT cycles, with no idle gap between queued frames.
REQ-021 SHALL set busy = (state!=IDLE) or (count!=0).
REQ-022 SHALL give latency for a write accepted at edge N into an empty, idle block as: count=1 after edge N, txd falls after edge N+1, and the frame ends after edge N+1+10*CLKS_PER_BIT.
REQ-023 SHALL decrement count on a pop at the same edge as it leaves IDLE or STOP, so a full FIFO regains wr_ready in the cycle after the pop.

Reset
REQ-024 SHALL, while resetn is low at a rising edge, set state=IDLE, txd=1, count=0, pointers=0, and baud counter and bit index=0.
REQ-025 SHALL on reset mid-frame abort the frame immediately (txd=1 after that edge) and discard all queued bytes.
REQ-026 SHALL after reset give wr_ready=1 and busy=0; FIFO storage contents are don't-care.
REQ-027 SHALL ignore wr_en in any cycle where resetn is low.

Verification
REQ-028 SHALL cover, with CLKS_PER_BIT=4: write 0x55 when idle -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy low after cycle 40 of the frame.
REQ-029 SHALL cover: write 0xA3,0x0F back-to-back -> two contiguous 40-cycle frames, LSB first, no idle cycle between the STOP of frame 1 and the START of frame 2.
REQ-030 SHALL cover, with FIFO_DEPTH=4: write 6 bytes on consecutive cycles -> 5 accepted (1 popped + 4 queued), wr_ready low from then until the next pop, 6th byte dropped, 5 frames observed.
REQ-031 SHALL cover: with the FIFO full and a pop due, assert wr_en on the pop cycle -> write rejected and count=FIFO_DEPTH-1 after the edge.
REQ-032 SHALL cover: resetn low for 1 cycle during DATA bit 3 with 2 bytes queued -> txd=1 next cycle, busy=0, wr_ready=1, and no further frames.
REQ-033 SHALL cover, with CLKS_PER_BIT=2: write 0xFF -> a 20-cycle frame with txd low only for the 2 start-bit cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte-wide UART transmitter (8N1) fed by a small in-order FIFO.
//            Frames are start bit (0), eight data bits LSB first, stop bit (1),
//            each bit held for CLKS_PER_BIT clocks. Queued bytes are sent
//            back-to-back with no idle gap between frames.
// Ports    : clk       - system clock, all state changes on its rising edge
//            resetn    - synchronous active-low reset
//            wr_en     - store strobe, byte on wr_data offered this cycle
//            wr_data   - byte to transmit
//            wr_ready  - FIFO not full; a write lands only if wr_en & wr_ready
//            busy      - FIFO non-empty or a frame in progress
//            txd       - registered serial line, idle high
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,   // 2..65535
  parameter int FIFO_DEPTH   = 4     // power of two, 2..16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       txd
);

  localparam int              AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   C_FULL      = CW'(FIFO_DEPTH);
  localparam logic [15:0]     C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [15:0]     baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            txd_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_baud_end;
  logic [7:0]      w_head;

  assign w_baud_end = (baud_q == C_BAUD_LAST);
  assign w_head     = mem_q[rd_ptr_q];

  assign wr_ready   = (count_q != C_FULL);
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign txd        = txd_q;

  // A write offered while full is dropped outright, even if a pop frees a
  // slot on the same edge; the slot only shows up as wr_ready next cycle.
  assign w_push = resetn && wr_en && wr_ready;

  // Pops happen only where a new frame is launched: from IDLE, or at the
  // last clock of a stop bit so the next start bit follows without a gap.
  assign w_pop  = (count_q != '0) &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && w_baud_end));

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (w_pop) begin
            shift_q <= w_head;
            txd_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // Shift right so the next bit to send always sits at shift_q[1].
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (w_pop) begin
              shift_q <= w_head;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          baud_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Two instances (4 and 2
//            clocks per bit). A transaction-level model tracks queued bytes
//            and frame occupancy; every launched frame is pushed to a
//            scoreboard with its expected start cycle. A line decoder pops
//            the scoreboard whenever a start bit appears and checks start
//            time and every bit cell of the frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CPB0  = 4;
  localparam int CPB1  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] resetn;
  logic [1:0] wr_en;
  logic [7:0] wr_data [2];
  logic [1:0] wr_ready;
  logic [1:0] busy;
  logic [1:0] txd;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk      (clk),
    .resetn   (resetn[0]),
    .wr_en    (wr_en[0]),
    .wr_data  (wr_data[0]),
    .wr_ready (wr_ready[0]),
    .busy     (busy[0]),
    .txd      (txd[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk      (clk),
    .resetn   (resetn[1]),
    .wr_en    (wr_en[1]),
    .wr_data  (wr_data[1]),
    .wr_ready (wr_ready[1]),
    .busy     (busy[1]),
    .txd      (txd[1])
  );

  function automatic int cpb_of(input int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  // ---------------- reference model (updated on rising edges) -------------
  int         cyc = 0;
  logic [7:0] mfifo [2][$];
  logic [7:0] sb_b  [2][$];
  int         sb_t  [2][$];
  int         m_left [2] = '{0, 0};   // clocks left in the frame on the line
  int         rst_ev [2] = '{0, 0};
  int         mdl_sz;
  bit         mdl_acc, mdl_pop;
  logic [7:0] mdl_b;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!resetn[i]) begin
        mfifo[i].delete();
        sb_b[i].delete();
        sb_t[i].delete();
        m_left[i] = 0;
        rst_ev[i] = rst_ev[i] + 1;
      end else begin
        mdl_sz  = mfifo[i].size();
        mdl_acc = wr_en[i] && (mdl_sz != DEPTH);
        // A new frame starts when the line is free or the current frame is
        // in its final clock, provided something was already queued.
        mdl_pop = (mdl_sz > 0) && (m_left[i] <= 1);
        if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
        if (mdl_acc) mfifo[i].push_back(wr_data[i]);
        if (mdl_pop) begin
          mdl_b = mfifo[i].pop_front();
          sb_b[i].push_back(mdl_b);
          sb_t[i].push_back(cyc);
          m_left[i] = 10 * cpb_of(i);
        end
      end
    end
  end

  // ---------------- monitor / checker (falling edges) ---------------------
  int         n_chk = 0;
  int         n_fail = 0;
  bit         stim_done = 1'b0;
  bit         stim_to = 1'b0;
  int         drain = 0;
  bit         dec_active [2] = '{1'b0, 1'b0};
  logic [7:0] dec_byte [2];
  int         dec_k [2] = '{0, 0};
  int         dec_rst [2] = '{0, 0};
  int         mon_bi, mon_eb, mon_t;
  logic [7:0] mon_byte;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, i, cyc, act, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dec_rst[i] != rst_ev[i]) begin
        dec_rst[i]    = rst_ev[i];
        dec_active[i] = 1'b0;
      end
      chk("wr_ready", i, int'(wr_ready[i]), int'(mfifo[i].size() != DEPTH));
      chk("busy", i, int'(busy[i]), int'((m_left[i] != 0) || (mfifo[i].size() != 0)));
      if (!dec_active[i]) begin
        if (txd[i] == 1'b0) begin
          if (sb_b[i].size() == 0) begin
            chk("unexpected_frame", i, 1, 0);
          end else begin
            dec_byte[i]   = sb_b[i].pop_front();
            mon_t         = sb_t[i].pop_front();
            chk("frame_start_cycle", i, cyc, mon_t);
            dec_active[i] = 1'b1;
            dec_k[i]      = 0;
          end
        end else begin
          // Line high with no frame decoded: model must agree nothing is due.
          chk("txd_high_frame_due", i, int'(m_left[i] != 0), 0);
        end
      end
      if (dec_active[i]) begin
        mon_bi   = dec_k[i] / cpb_of(i);
        mon_byte = dec_byte[i];
        if (mon_bi == 0)      mon_eb = 0;
        else if (mon_bi == 9) mon_eb = 1;
        else                  mon_eb = int'(mon_byte[mon_bi-1]);
        chk("txd_bit", i, int'(txd[i]), mon_eb);
        dec_k[i] = dec_k[i] + 1;
        if (dec_k[i] == 10 * cpb_of(i)) dec_active[i] = 1'b0;
      end
    end

    if (stim_done) begin
      drain = drain + 1;
      if ((m_left[0] == 0 && m_left[1] == 0 && mfifo[0].size() == 0 &&
           mfifo[1].size() == 0 && !dec_active[0] && !dec_active[1]) || drain > 3000) begin
        chk("drain_timeout", 0, int'(drain > 3000), 0);
        chk("stim_wait_timeout", 0, int'(stim_to), 0);
        for (int i = 0; i < 2; i++) begin
          chk("frames_outstanding", i, sb_b[i].size(), 0);
          chk("final_busy", i, int'(busy[i]), 0);
          chk("final_wr_ready", i, int'(wr_ready[i]), 1);
          chk("final_txd", i, int'(txd[i]), 1);
        end
        summary();
        $finish;
      end
    end
    if (cyc > 40000) begin
      chk("global_timeout", 0, 1, 0);
      summary();
      $finish;
    end
  end

  // ---------------- stimulus (driven on falling edges) --------------------
  task automatic put(input int i, input logic [7:0] d);
    wr_en[i]   = 1'b1;
    wr_data[i] = d;
    @(negedge clk);
    wr_en[i]   = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 3000; k++) begin
      if (!busy[i]) return;
      @(negedge clk);
    end
    stim_to = 1'b1;
  endtask

  // Hold wr_en high until the byte is taken; exercises writes offered on
  // the very cycle a pop frees a slot.
  task automatic put_until_taken(input int i, input logic [7:0] d);
    bit acc;
    wr_en[i]   = 1'b1;
    wr_data[i] = d;
    for (int k = 0; k < 500; k++) begin
      acc = wr_ready[i];
      @(negedge clk);
      if (acc) break;
    end
    wr_en[i] = 1'b0;
  endtask

  initial begin
    resetn     = 2'b00;
    wr_en      = 2'b00;
    wr_data[0] = 8'h00;
    wr_data[1] = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 2'b11;
    repeat (2) @(negedge clk);

    // single byte into an idle block
    put(0, 8'h55);
    wait_idle(0);
    repeat (3) @(negedge clk);

    // two bytes back to back: contiguous frames
    put(0, 8'hA3);
    put(0, 8'h0F);
    wait_idle(0);
    repeat (2) @(negedge clk);

    // six consecutive writes: one launched, four queued, sixth dropped
    for (int k = 0; k < 6; k++) put(0, 8'($urandom));
    wait_idle(0);

    // fill, then keep offering a byte through the pop cycle
    for (int k = 0; k < 5; k++) put(0, 8'($urandom));
    put_until_taken(0, 8'hC6);
    wait_idle(0);

    // reset during data bit 3 with two bytes queued
    put(0, 8'h96);
    put(0, 8'h3C);
    put(0, 8'hE1);
    repeat (16) @(negedge clk);
    resetn[0] = 1'b0;
    @(negedge clk);
    resetn[0] = 1'b1;
    repeat (150) @(negedge clk);

    // random traffic with one reset pulse in the middle
    for (int k = 0; k < 120; k++) begin
      wr_en[0]   = ($urandom_range(0, 2) == 0);
      wr_data[0] = 8'($urandom);
      resetn[0]  = (k != 70);
      @(negedge clk);
    end
    wr_en[0]  = 1'b0;
    resetn[0] = 1'b1;
    wait_idle(0);

    // two clocks per bit: all-ones byte, then a short random burst
    put(1, 8'hFF);
    wait_idle(1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) put(1, 8'($urandom));
    wait_idle(1);

    repeat (4) @(negedge clk);
    stim_done = 1'b1;
  end

endmodule
`default_nettype wire
